// File: rtl/relogio_pkg.sv
// Shared types, moduli and helpers for the BCD clock datapath.
package relogio_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_t;

    localparam int unsigned HORA_MOD = 24;
    localparam int unsigned MIN_MOD  = 60;
    localparam int unsigned SEG_MOD  = 60;

    // True when msd:lsd is a proper BCD pair whose value lies below mod.
    function automatic logic bcd_valid(input bcd_t msd, input bcd_t lsd, input int unsigned mod);
        int unsigned value;
        value = (32'(msd) * 32'd10) + 32'(lsd);
        return (lsd <= 4'd9) && (value < mod);
    endfunction

endpackage

// File: rtl/conv_12h.sv
// Combinational 24h -> 12h BCD view with pm flag (00 shows as 12).
module conv_12h
    import relogio_pkg::*;
(
    input  logic [1:0] msd24,
    input  bcd_t       lsd24,
    output logic [1:0] msd12,
    output bcd_t       lsd12,
    output logic       pm
);

    logic [5:0] value;
    logic [5:0] hour;

    always_comb begin
        value = (6'(msd24) * 6'd10) + 6'(lsd24);
        if (value == 6'd0) begin
            hour = 6'd12;
        end else if (value > 6'd12) begin
            hour = value - 6'd12;
        end else begin
            hour = value;
        end
        pm = (value >= 6'd12);
        if (hour >= 6'd10) begin
            msd12 = 2'd1;
            lsd12 = 4'(hour - 6'd10);
        end else begin
            msd12 = 2'd0;
            lsd12 = 4'(hour);
        end
    end

endmodule

// File: rtl/maq_tempo_bcd.sv
// Two-digit BCD time-unit counter: up/down with carry/borrow, validated load,
// optional 12h display view.
module maq_tempo_bcd
    import relogio_pkg::*;
#(
    parameter int unsigned MOD       = HORA_MOD,
    parameter int unsigned MSD_W     = 2,
    parameter bit          MODE12_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [3:0]       load_lsd,
    input  logic [MSD_W-1:0] load_msd,
    input  logic             mode12,
    output logic [3:0]       bcd_lsd,
    output logic [MSD_W-1:0] bcd_msd,
    output logic             pm,
    output logic             carry,
    output logic             borrow,
    output logic             load_err
);

    if ((MOD < 2) || (MOD > 99)) begin : g_bad_mod
        $error("maq_tempo_bcd: MOD must lie in 2..99");
    end
    if ((MSD_W < 1) || (MSD_W > 4) || (((MOD - 1) / 10) >= (1 << MSD_W))) begin : g_bad_msd_w
        $error("maq_tempo_bcd: MSD_W cannot hold the tens digit of MOD-1");
    end
    if (MODE12_EN && (MOD != 24)) begin : g_bad_mode12
        $error("maq_tempo_bcd: MODE12_EN requires MOD == 24");
    end

    localparam logic [MSD_W-1:0] TOP_MSD = MSD_W'((MOD - 1) / 10);
    localparam bcd_t             TOP_LSD = 4'((MOD - 1) % 10);

    logic [MSD_W-1:0] cnt_msd;
    bcd_t             cnt_lsd;
    logic             state_ok;
    logic             load_ok;
    logic             at_top;
    logic             at_zero;
    op_t              op;

    assign state_ok = bcd_valid(4'(cnt_msd), cnt_lsd, MOD);
    assign load_ok  = bcd_valid(4'(load_msd), load_lsd, MOD);
    assign at_top   = (cnt_msd == TOP_MSD) && (cnt_lsd == TOP_LSD);
    assign at_zero  = (cnt_msd == '0) && (cnt_lsd == '0);

    always_comb begin
        if (load) begin
            op = OP_LOAD;
        end else if (inc && !dec) begin
            op = OP_INC;
        end else if (dec && !inc) begin
            op = OP_DEC;
        end else begin
            op = OP_HOLD;
        end
    end

    // An out-of-range state (only reachable via X/force) is cleared by the next step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_msd  <= '0;
            cnt_lsd  <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
            case (op)
                OP_LOAD: begin
                    if (load_ok) begin
                        cnt_msd <= load_msd;
                        cnt_lsd <= load_lsd;
                    end else begin
                        load_err <= 1'b1;
                    end
                end
                OP_INC: begin
                    if (!state_ok) begin
                        cnt_msd <= '0;
                        cnt_lsd <= '0;
                    end else if (at_top) begin
                        cnt_msd <= '0;
                        cnt_lsd <= '0;
                        carry   <= 1'b1;
                    end else if (cnt_lsd == 4'd9) begin
                        cnt_msd <= cnt_msd + MSD_W'(1);
                        cnt_lsd <= '0;
                    end else begin
                        cnt_lsd <= cnt_lsd + 4'd1;
                    end
                end
                OP_DEC: begin
                    if (!state_ok) begin
                        cnt_msd <= '0;
                        cnt_lsd <= '0;
                    end else if (at_zero) begin
                        cnt_msd <= TOP_MSD;
                        cnt_lsd <= TOP_LSD;
                        borrow  <= 1'b1;
                    end else if (cnt_lsd == 4'd0) begin
                        cnt_msd <= cnt_msd - MSD_W'(1);
                        cnt_lsd <= 4'd9;
                    end else begin
                        cnt_lsd <= cnt_lsd - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    if (MODE12_EN) begin : g_12h
        logic [1:0] msd12;
        bcd_t       lsd12;
        logic       pm12;

        conv_12h u_conv (
            .msd24 (cnt_msd[1:0]),
            .lsd24 (cnt_lsd),
            .msd12 (msd12),
            .lsd12 (lsd12),
            .pm    (pm12)
        );

        always_comb begin
            if (mode12) begin
                bcd_msd = MSD_W'(msd12);
                bcd_lsd = lsd12;
            end else begin
                bcd_msd = cnt_msd;
                bcd_lsd = cnt_lsd;
            end
        end

        assign pm = pm12;
    end else begin : g_24h
        logic unused_mode12;

        assign unused_mode12 = mode12;
        assign bcd_msd       = cnt_msd;
        assign bcd_lsd       = cnt_lsd;
        assign pm            = 1'b0;
    end

endmodule
